fifo_rd_ctrl: RTL

Read-side controller for the async FIFO, running entirely in the read clock domain. It owns the read pointer and compares it against the synchronized Gray write pointer. It issues reads to the dual-port RAM, which has one cycle of read latency, and presents data to the consumer through a 2-entry first-word-fall-through output buffer with a valid/ready handshake. It publishes the Gray read pointer for synchronization back into the write domain.

---
 rtl/fifo_rd_ctrl_if.sv | 23 ++
 rtl/fifo_rd_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle of the async FIFO: RAM read port plus the consumer valid/ready stream.
// The controller takes the master modport; the RAM/consumer side takes the slave modport.
interface fifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output mem_rd_en, mem_rd_addr, m_valid, m_data,
        input  mem_rd_data, m_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, m_valid, m_data,
        output mem_rd_data, m_ready
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointer, RAM read issue with one-cycle latency,
// and a 2-entry first-word-fall-through output buffer, all in the rd_clk domain.
module fifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [ADDR_WIDTH:0]   ram_level,
    output logic                  ptr_err,
    fifo_rd_ctrl_if.master        bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] HALF_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0]         wr_bin;
    logic [PW-1:0]         rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PW-1:0]         rd_ptr_gray_q, rd_ptr_gray_d;
    logic [PW-1:0]         ram_level_q, ram_level_d;
    logic [PW-1:0]         rd_diff;
    logic                  ptr_err_q, ptr_err_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  head_q, head_d;
    logic                  tail;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [1:0]            outstanding;
    logic                  inflight_q;
    logic                  mem_avail;
    logic                  pop;
    logic                  issue;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
        assign wr_bin[gi] = ^wr_ptr_gray_sync[PW-1:gi];
    end

    always_comb begin
        mem_avail     = (rd_ptr_gray_q != wr_ptr_gray_sync);
        pop           = (buf_cnt_q != 2'd0) && bus.m_ready;
        outstanding   = buf_cnt_q + {1'b0, inflight_q};
        issue         = mem_avail && ((outstanding <= 2'd1) || pop);
        rd_ptr_bin_d  = rd_ptr_bin_q + {{ADDR_WIDTH{1'b0}}, issue};
        rd_ptr_gray_d = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
        ram_level_d   = wr_bin - rd_ptr_bin_d;
        rd_diff       = wr_bin - rd_ptr_bin_q;
        ptr_err_d     = ptr_err_q || (rd_diff > HALF_SPAN);
        tail          = head_q ^ buf_cnt_q[0];
        buf_cnt_d     = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
        // Head only moves when another word remains, so m_data holds its last value when empty.
        head_d        = head_q ^ (pop && ((buf_cnt_q == 2'd2) || inflight_q));
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            ram_level_q   <= '0;
            ptr_err_q     <= 1'b0;
            head_q        <= 1'b0;
            buf_cnt_q     <= 2'd0;
            inflight_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            ram_level_q   <= ram_level_d;
            ptr_err_q     <= ptr_err_d;
            head_q        <= head_d;
            buf_cnt_q     <= buf_cnt_d;
            inflight_q    <= issue;
            if (inflight_q) begin
                buf_q[tail] <= bus.mem_rd_data;
            end
        end
    end

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign bus.m_valid     = (buf_cnt_q != 2'd0);
    assign bus.m_data      = buf_q[head_q];
    assign rd_ptr_gray     = rd_ptr_gray_q;
    assign ram_level       = ram_level_q;
    assign ptr_err         = ptr_err_q;
endmodule
